vicii_bus_arbiter: RTL
======================

# vicii_bus_arbiter

Memory-side responder for VIC-II DMA requests. It collects the `ba`/`ao` requests from the eight sprite units and the graphics (c-access) fetcher and drives the shared VIC-II memory address bus. It returns fetched bytes on the common `di` bus and steals CPU bus cycles through `rdy`/`aec` with the standard 3-cycle BA→AEC delay. It sits between the sprite/graphics units and the system memory mux in the VIC-II top level.

## Interface

**Parameters**
- `STEAL_DELAY`, default 3: number of CPU-half starts with `rdy` low before `aec` is taken (1..7).

**Ports**
- `clk` in 1: system pixel clock.
- `reset` in 1: synchronous, active-high.
- `ph` in 1: bus phase level, 0 = VIC half, 1 = CPU half. A "CPU-half start" is a clk where `ph`=1 and the previous `ph`=0.
- `sprite_ao` in 112: packed sprite addresses, sprite n on bits [14n+13:14n]. Requesters drive 0 when not addressing.
- `sprite_ba` in 8: per-sprite bus request.
- `gfx_ao` in 14: graphics fetcher address, 0 when idle.
- `gfx_ba` in 1: graphics fetcher (badline) request.
- `cpu_a` in 14: CPU-side VIC bank address.
- `mem_d` in 8: data from memory.
- `mem_a` out 14: registered memory address.
- `di` out 8: registered read data, broadcast to all requesters.
- `rdy` out 1: CPU ready; 0 = CPU must halt on next read.
- `aec` out 1: 1 = CPU owns the CPU half, 0 = VIC owns both halves.
- `dma` out 1: 1 while in state OWN.

## Operation
- `req` = OR of `sprite_ba[7:0]` and `gfx_ba`.
- `vic_a` = bitwise OR of the eight `sprite_ao` slices and `gfx_ao`. Windows are non-overlapping by construction, so no priority is applied.
- Address mux, registered each clk:
  - `ph`=0: `mem_a` <= `vic_a`.
  - `ph`=1 and `aec`=0: `mem_a` <= `vic_a`.
  - `ph`=1 and `aec`=1: `mem_a` <= `cpu_a`.
- `di` <= `mem_d` every clk, unconditionally.
- State machine, 3-bit counter `cnt`:
  - **IDLE**: `rdy`=1, `aec`=1. If `req`, go to STEAL with `cnt`=0 and `rdy`<=0 on the same edge.
  - **STEAL**: `rdy`=0, `aec`=1.
    - Each CPU-half start with `req` high increments `cnt`.
    - On the CPU-half start where `cnt`==`STEAL_DELAY`-1, go to OWN and set `aec`<=0.
    - If `req` drops, go to IDLE and set `rdy`<=1 on the next edge; `aec` never falls.
  - **OWN**: `rdy`=0, `aec`=0, `dma`=1. When `req`=0, go to RELEASE.
  - **RELEASE**: `rdy`<=1 immediately. `aec` stays 0 until the next CPU-half start, then `aec`<=1 and go to IDLE.
    - If `req` reasserts before that CPU-half start, go to STEAL with `cnt`=0 and `rdy`<=0. `aec` returns to 1 for the steal window, because the CPU must get its 3 write cycles.

## Timing
- Reset values: `mem_a`=0, `di`=0, `rdy`=1, `aec`=1, `dma`=0, state IDLE, `cnt`=0. Reset mid-STEAL or mid-OWN returns all of these on the next edge.
- `mem_a` and `di` have 1 clk latency from their inputs.
- `rdy` falls 1 clk after `req` rises.
- `aec` falls on the `STEAL_DELAY`-th CPU-half start after `rdy` fell. A CPU-half start on the same clk as the `req` rise does not count.
- `aec` rises on the first CPU-half start after `req`=0 has been seen in OWN.
- `req` toggling within one clk in IDLE still produces a 1-clk `rdy` low pulse.
- `cnt` saturates at `STEAL_DELAY`-1 and never wraps.

## Test plan
- **Reset**: assert `reset` for 2 clk during OWN → `rdy`=1, `aec`=1, `dma`=0, `mem_a`=0, `di`=0 on the next edge.
- **Sprite steal**:
  - Stimulus: `sprite_ba[2]` rises, `ph` toggles every 4 clk.
  - Response: `rdy`=0 after 1 clk; `aec`=0 exactly at the 3rd CPU-half start; `mem_a` tracks `sprite_ao[41:28]` (e.g. 0x3FFA) 1 clk later, in both halves.
- **Aborted steal**: `gfx_ba` high for 1 CPU-half start then low → `rdy` returns to 1, `aec` stays 1 throughout, `dma` never set.
- **Release and re-request**: drop all `ba` in OWN, reassert 2 clk later (before the next CPU-half start) → `rdy`=1 for 2 clk, then STEAL with `cnt`=0; `aec`=1 for 3 CPU-half starts, then 0.
- **CPU passthrough**: IDLE, `ph`=1, `cpu_a`=0x1234 → `mem_a`=0x1234 1 clk later; `ph`=0 with `vic_a`=0x0400 → `mem_a`=0x0400.
- **Data path**: `mem_d`=0xA5 applied for 1 clk → `di`=0xA5 on the following clk; the next `mem_d`=0x5A replaces it 1 clk later.

Source files
------------

// File: rtl/vicii_bus_arbiter.sv
// VIC-II DMA bus arbiter: merges sprite/graphics fetch requests, muxes the memory address
// and steals CPU cycles through rdy/aec with a configurable BA->AEC delay.
module vicii_bus_arbiter #(
    parameter int unsigned STEAL_DELAY = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ph,
    input  logic [111:0] sprite_ao,
    input  logic [7:0]   sprite_ba,
    input  logic [13:0]  gfx_ao,
    input  logic         gfx_ba,
    input  logic [13:0]  cpu_a,
    input  logic [7:0]   mem_d,
    output logic [13:0]  mem_a,
    output logic [7:0]   di,
    output logic         rdy,
    output logic         aec,
    output logic         dma
);

    typedef enum logic [1:0] {
        StIdle,
        StSteal,
        StOwn,
        StRelease
    } state_e;

    localparam logic [2:0] CntLast = 3'(STEAL_DELAY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        aec_q, aec_d;
    logic        dma_q, dma_d;
    logic        ph_q;
    logic [13:0] mem_a_q, mem_a_d;
    logic [7:0]  di_q;
    logic [13:0] vic_a;
    logic        req;
    logic        cpu_start;

    assign req       = (|sprite_ba) | gfx_ba;
    assign cpu_start = ph & ~ph_q;

    // Requester address windows never overlap, so a plain OR merges them.
    always_comb begin
        vic_a = gfx_ao;
        for (int i = 0; i < 8; i++) begin
            vic_a = vic_a | sprite_ao[14*i +: 14];
        end
    end

    always_comb begin
        mem_a_d = (!ph || !aec_q) ? vic_a : cpu_a;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        aec_d   = aec_q;
        dma_d   = dma_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StSteal;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            StSteal: begin
                if (!req) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end else if (cpu_start) begin
                    if (cnt_q == CntLast) begin
                        state_d = StOwn;
                        aec_d   = 1'b0;
                        dma_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StOwn: begin
                if (!req) begin
                    state_d = StRelease;
                    rdy_d   = 1'b1;
                    dma_d   = 1'b0;
                end
            end
            StRelease: begin
                // A fresh request restarts the steal window so the CPU can finish its writes.
                if (req) begin
                    state_d = StSteal;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                    aec_d   = 1'b1;
                end else if (cpu_start) begin
                    state_d = StIdle;
                    aec_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            aec_q   <= 1'b1;
            dma_q   <= 1'b0;
            ph_q    <= 1'b0;
            mem_a_q <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            aec_q   <= aec_d;
            dma_q   <= dma_d;
            ph_q    <= ph;
            mem_a_q <= mem_a_d;
            di_q    <= mem_d;
        end
    end

    assign mem_a = mem_a_q;
    assign di    = di_q;
    assign rdy   = rdy_q;
    assign aec   = aec_q;
    assign dma   = dma_q;

endmodule
